// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle program-counter controller for the 20-bit datapath.
// Steps each instruction through FETCH, DECODE, EXECUTE and UPDATE, drives the
// instruction-memory handshake and resolves conditional branches.
// Optional feature macro: BRANCH_LINK_EN adds dec_link / link_pc (branch-and-link).
module pc_sequencer #(
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [19:0] imem_addr,
  input  logic        imem_ack,
  input  logic [19:0] imem_data,
  output logic [19:0] instr,
  output logic        instr_valid,
  input  logic        dec_branch,
  input  logic [2:0]  dec_nzp,
  input  logic [19:0] dec_offset,
  input  logic        dec_halt,
  input  logic        exec_done,
  input  logic [2:0]  cmp_flags,
  output logic [19:0] pc,
  output logic        branch_taken,
  output logic        busy,
  output logic        halted
`ifdef BRANCH_LINK_EN
  ,
  output logic [19:0] link_pc,
  input  logic        dec_link
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    UPDATE  = 3'd4,
    HALT    = 3'd5
  } state_t;

  state_t      state;
  logic        branch_l;
  logic [2:0]  nzp_l;
  logic [19:0] offset_l;
`ifdef BRANCH_LINK_EN
  logic        link_l;
`endif

  // Fetch address is always the current PC.
  assign imem_addr = pc;

  // Sequencer FSM with registered outputs set on state entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= '0;
      branch_l     <= 1'b0;
      nzp_l        <= '0;
      offset_l     <= '0;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      branch_taken <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
`ifdef BRANCH_LINK_EN
      link_l       <= 1'b0;
      link_pc      <= '0;
`endif
    end else begin
      instr_valid  <= 1'b0;
      branch_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= DECODE;
          end
        end
        DECODE: begin
          branch_l <= dec_branch;
          nzp_l    <= dec_nzp;
          offset_l <= dec_offset;
`ifdef BRANCH_LINK_EN
          link_l   <= dec_link;
`endif
          if (dec_halt) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          // The compare flags are folded into the taken decision as they are
          // captured; branch_taken then serves as the latched decision in UPDATE.
          if (exec_done) begin
            branch_taken <= branch_l & (|(nzp_l & cmp_flags));
            state        <= UPDATE;
          end
        end
        UPDATE: begin
          if (branch_taken) begin
            pc <= pc + offset_l;
          end else begin
            pc <= pc + 20'd1;
          end
`ifdef BRANCH_LINK_EN
          if (branch_taken && link_l) begin
            link_pc <= pc + 20'd1;
          end
`endif
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [19:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [19:0] imem_data = '0;
  logic [19:0] instr;
  logic        instr_valid;
  logic        dec_branch = 1'b0;
  logic [2:0]  dec_nzp = '0;
  logic [19:0] dec_offset = '0;
  logic        dec_halt = 1'b0;
  logic        exec_done = 1'b0;
  logic [2:0]  cmp_flags = '0;
  logic [19:0] pc;
  logic        branch_taken;
  logic        busy;
  logic        halted;
`ifdef BRANCH_LINK_EN
  logic [19:0] link_pc;
  logic        dec_link = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  // Observations captured while an instruction is stepped through.
  logic [19:0] addr0;
  logic [19:0] instr_seen;
  logic        valid_seen;
  logic        req_after_ack;
  logic        saw_taken;
  logic        taken_after;
  int          reqcyc;
  int          edges;

  pc_sequencer #(.RESET_PC(20'h00000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
    .dec_branch(dec_branch), .dec_nzp(dec_nzp), .dec_offset(dec_offset),
    .dec_halt(dec_halt), .exec_done(exec_done), .cmp_flags(cmp_flags),
    .pc(pc), .branch_taken(branch_taken), .busy(busy), .halted(halted)
`ifdef BRANCH_LINK_EN
    , .link_pc(link_pc), .dec_link(dec_link)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps one non-halting instruction from its first FETCH cycle to the next FETCH.
  task automatic do_instr(input logic br, input logic [2:0] nzp, input logic [19:0] off,
                          input logic [2:0] cmp, input logic lnk, input int ack_wait,
                          input logic [19:0] data);
    addr0 = imem_addr;
    reqcyc = 0;
    edges = 0;
    dec_branch = br;
    dec_nzp = nzp;
    dec_offset = off;
    dec_halt = 1'b0;
    cmp_flags = cmp;
    exec_done = 1'b1;
    imem_data = data;
`ifdef BRANCH_LINK_EN
    dec_link = lnk;
`else
    if (lnk) dec_halt = 1'b0;
`endif
    for (int k = 1; k <= ack_wait; k++) begin
      if (imem_req === 1'b1) reqcyc++;
      imem_ack = (k == ack_wait);
      tick();
      edges++;
    end
    imem_ack = 1'b0;
    instr_seen = instr;
    valid_seen = instr_valid;
    req_after_ack = imem_req;
    tick(); edges++;
    tick(); edges++;
    saw_taken = branch_taken;
    tick(); edges++;
    taken_after = branch_taken;
    exec_done = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_taken", 32'(branch_taken), 32'h0);
    reset = 1'b0;
    tick();
    check("idle_no_start", 32'(busy), 32'h0);

    // Start held high: one run begins
    start = 1'b1;
    tick();
    check("start_req", 32'(imem_req), 32'h1);
    check("start_busy", 32'(busy), 32'h1);

    // Three sequential non-branch instructions
    for (int i = 0; i < 3; i++) begin
      do_instr(1'b0, 3'b111, 20'h00005, 3'b111, 1'b0, 1, 20'hA5000 + 20'(i));
      check($sformatf("seq_addr%0d", i), 32'(addr0), 32'(i));
      check($sformatf("seq_edges%0d", i), 32'(edges), 32'd4);
      check($sformatf("seq_instr%0d", i), 32'(instr_seen), 32'hA5000 + 32'(i));
      check($sformatf("seq_valid%0d", i), 32'(valid_seen), 32'h1);
      check($sformatf("seq_taken%0d", i), 32'(saw_taken), 32'h0);
    end
    start = 1'b0;
    check("seq_pc3", 32'(pc), 32'h3);
    check("seq_addr3", 32'(imem_addr), 32'h3);

    // Forward branch 3 -> 0x10
    do_instr(1'b1, 3'b010, 20'h0000D, 3'b010, 1'b0, 1, 20'h11111);
    check("fwd_taken", 32'(saw_taken), 32'h1);
    check("fwd_pc", 32'(pc), 32'h10);

    // Backward branch by -8 at 0x10
    do_instr(1'b1, 3'b010, 20'hFFFF8, 3'b010, 1'b0, 1, 20'h22222);
    check("back_taken", 32'(saw_taken), 32'h1);
    check("back_pulse_width", 32'(taken_after), 32'h0);
    check("back_pc", 32'(pc), 32'h8);

    // Return to 0x10, then same branch with non-matching flags
    do_instr(1'b1, 3'b001, 20'h00008, 3'b001, 1'b0, 1, 20'h33333);
    check("ret_pc", 32'(pc), 32'h10);
    do_instr(1'b1, 3'b010, 20'hFFFF8, 3'b100, 1'b0, 1, 20'h44444);
    check("nt_taken", 32'(saw_taken), 32'h0);
    check("nt_pc", 32'(pc), 32'h11);

    // nzp=000 never taken
    do_instr(1'b1, 3'b000, 20'h00100, 3'b111, 1'b0, 1, 20'h55555);
    check("nzp0_taken", 32'(saw_taken), 32'h0);
    check("nzp0_pc", 32'(pc), 32'h12);

    // nzp=111 taken on any flag; wraps backward 0x12 - 0x13 = 0xFFFFF
    do_instr(1'b1, 3'b111, 20'hFFFED, 3'b001, 1'b0, 1, 20'h66666);
    check("nzp7_taken", 32'(saw_taken), 32'h1);
    check("wrap_back_pc", 32'(pc), 32'hFFFFF);

    // Non-branch at 0xFFFFF wraps to 0, fetch ack delayed to 5th cycle
    do_instr(1'b0, 3'b111, 20'h00000, 3'b111, 1'b0, 5, 20'h77777);
    check("slow_addr", 32'(addr0), 32'hFFFFF);
    check("slow_req_cycles", 32'(reqcyc), 32'd5);
    check("slow_req_drop", 32'(req_after_ack), 32'h0);
    check("slow_edges", 32'(edges), 32'd8);
    check("wrap_fwd_pc", 32'(pc), 32'h0);

    // Halt with branch also flagged
    dec_halt = 1'b1;
    dec_branch = 1'b1;
    dec_nzp = 3'b111;
    cmp_flags = 3'b111;
    exec_done = 1'b1;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_busy", 32'(busy), 32'h0);
    check("halt_pc", 32'(pc), 32'h0);
    start = 1'b1;
    imem_ack = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    imem_ack = 1'b0;
    check("halt_start_ignored", 32'(halted), 32'h1);
    check("halt_no_req", 32'(imem_req), 32'h0);
    dec_halt = 1'b0;
    exec_done = 1'b0;

    // Reset mid-EXECUTE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_instr(1'b0, 3'b000, 20'h0, 3'b000, 1'b0, 1, 20'h00001);
    check("pre_rst_pc", 32'(pc), 32'h1);
    exec_done = 1'b0;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    check("exec_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_pc", 32'(pc), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_req", 32'(imem_req), 32'h0);
    exec_done = 1'b1;
    tick();
    check("midrst_idle", 32'(busy), 32'h0);
    exec_done = 1'b0;

`ifdef BRANCH_LINK_EN
    // Branch-and-link
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lnk_rst", 32'(link_pc), 32'h0);
    do_instr(1'b1, 3'b100, 20'h00040, 3'b100, 1'b0, 1, 20'h0);
    check("lnk_pre_pc", 32'(pc), 32'h40);
    check("lnk_nolink", 32'(link_pc), 32'h0);
    do_instr(1'b1, 3'b100, 20'h00010, 3'b100, 1'b1, 1, 20'h0);
    check("lnk_taken_link", 32'(link_pc), 32'h41);
    check("lnk_taken_pc", 32'(pc), 32'h50);
    do_instr(1'b1, 3'b100, 20'h00010, 3'b001, 1'b1, 1, 20'h0);
    check("lnk_nt_link", 32'(link_pc), 32'h41);
    check("lnk_nt_pc", 32'(pc), 32'h51);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter controller for the 20-bit processor datapath. It owns the PC register and steps each instruction through fetch, decode, execute and PC update. It drives the instruction-memory handshake and resolves conditional branches: a branch is taken when the instruction's nzp mask ANDed with the ALU compare flags is non-zero, and PC+1 is used otherwise. It sits between instruction memory, the decoder and the ALU/compare unit.

## Interface
- RESET_PC, 20'h00000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin execution from IDLE.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  20  fetch address; always equals pc.
- imem_ack  in  1  fetch complete; imem_data is valid in the same cycle.
- imem_data  in  20  instruction word.
- instr  out  20  latched instruction.
- instr_valid  out  1  one-cycle pulse while in DECODE.
- dec_branch  in  1  decoder flag: the instruction is a conditional branch; sampled in DECODE.
- dec_nzp  in  3  branch condition mask; sampled in DECODE.
- dec_offset  in  20  branch offset, two's complement; sampled in DECODE.
- dec_halt  in  1  the instruction is HALT; sampled in DECODE.
- exec_done  in  1  datapath finished executing.
- cmp_flags  in  3  {n,z,p} from the compare unit; sampled when exec_done=1 in EXECUTE.
- pc  out  20  current PC.
- branch_taken  out  1  one-cycle pulse in UPDATE when the branch is taken.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- link_pc  out  20  return address; present only with BRANCH_LINK_EN.
- dec_link  in  1  branch-and-link flag; sampled in DECODE; present only with BRANCH_LINK_EN.

## Operation
- States:
  - IDLE: start=1 goes to FETCH; otherwise stay.
  - FETCH: imem_req=1. On imem_ack=1, latch instr=imem_data and go to DECODE; otherwise stay.
  - DECODE: instr_valid=1. Latch dec_* inputs. dec_halt=1 goes to HALT (dec_halt has priority over dec_branch); otherwise go to EXECUTE.
  - EXECUTE: on exec_done=1, latch cmp_flags and go to UPDATE.
  - UPDATE: pc is updated as below, then go to FETCH.
  - HALT: terminal. Only reset leaves it.
- UPDATE rule:
  - taken = branch_l & |(nzp_l & cmp_l).
  - If taken, pc <= pc + offset_l, modulo 2^20, so wrap-around is allowed in both directions. Otherwise pc <= pc + 1, modulo 2^20; 20'hFFFFF wraps to 20'h00000.
  - A non-branch instruction always advances by 1, whatever nzp or cmp_flags are.
  - nzp=3'b000 is never taken. nzp=3'b111 is always taken when cmp_flags is non-zero.
- Ignored inputs:
  - start outside IDLE.
  - imem_ack outside FETCH.
  - exec_done outside EXECUTE.
  - dec_* outside DECODE.
- Reset values:
  - state=IDLE, pc=RESET_PC, instr=0, link_pc=0.
  - All single-bit outputs are 0.
- Reset mid-operation takes priority over every other input. At the next edge it returns the block to IDLE with pc=RESET_PC, drops imem_req, and discards any latched decode or compare data.

## Timing
- All state and register updates happen on the rising edge of clk. Outputs are registered or decoded from state only; there is no input-to-output combinational path.
- imem_req rises in the first FETCH cycle. It stays high until the cycle in which imem_ack=1 is sampled, and is low the next cycle.
- Minimum instruction latency is 4 cycles: FETCH (ack the same cycle), DECODE, EXECUTE (exec_done the same cycle), UPDATE.
- pc holds its new value from the cycle after UPDATE onward. The following FETCH presents the new value on imem_addr.
- branch_taken and instr_valid are exactly 1 cycle wide.
- start held high for many cycles starts exactly one run; it is re-sampled only in IDLE.

## Configuration
- BRANCH_LINK_EN defined:
  - Adds the dec_link and link_pc ports.
  - In UPDATE, when taken=1 and link_l=1, link_pc <= old pc + 1 (mod 2^20).
  - Otherwise link_pc holds its value.
- BRANCH_LINK_EN undefined: neither port exists and no link register is synthesized. All other behaviour is identical.

## Test plan
- Reset, then start. Fetch 3 non-branch instructions with immediate ack and exec_done → imem_addr sequence 0,1,2; pc=3 after the third UPDATE; each instruction takes 4 cycles.
- pc=20'h00010, dec_branch=1, nzp=3'b010, cmp_flags=3'b010, offset=20'hFFFF8 (-8) → branch_taken pulses; pc=20'h00008.
- Same branch with cmp_flags=3'b100 → no branch_taken pulse; pc=20'h00011.
- pc=20'hFFFFF with a non-branch instruction → pc=20'h00000. Separately, ack delayed 5 cycles → imem_req is high for exactly 5 cycles.
- dec_halt=1 together with dec_branch=1 → HALT, halted=1, pc unchanged, later start ignored. Reset asserted while in EXECUTE → next cycle IDLE, pc=RESET_PC, busy=0.
- With BRANCH_LINK_EN: taken link branch at pc=20'h00040 → link_pc=20'h00041. Not-taken link branch → link_pc unchanged.
